// File: rtl/mcpu5_prog_loader_if.sv
// mcpu5_prog_loader_if: valid/ready program-load channel into the MCPU5 program memory
interface mcpu5_prog_loader_if;
  logic       ld_valid;
  logic [5:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  modport master (output ld_valid, ld_data, ld_last, input ld_ready);
  modport slave (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/mcpu5_prog_loader.sv
// mcpu5_prog_loader: loadable MCPU5 program memory that pads, holds the core in reset, then serves fetches
module mcpu5_prog_loader #(
  parameter int          DEPTH    = 64,
  parameter logic [5:0]  PAD_WORD = 6'b000000,
  parameter int          RST_HOLD = 2,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  mcpu5_prog_loader_if.slave   ld,
  input  logic                 reload,
  input  logic [7:0]           addr,
  output logic [5:0]           instr,
  output logic                 cpu_reset,
  output logic [8:0]           prog_len
);
  typedef enum logic [1:0] {LOAD, PAD, HOLD, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [8:0]    prog_len_q, prog_len_d;
  logic [3:0]    hold_cnt_q, hold_cnt_d;
  logic          ld_ready_q, ld_ready_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic [5:0]    mem [DEPTH];
  logic          we;
  logic [5:0]    wdata;
  logic          accept, at_end;
  assign accept    = state_q == LOAD && ld.ld_valid && ld_ready_q;
  assign at_end    = wr_ptr_q == (AW+1)'(DEPTH - 1);
  assign ld.ld_ready = ld_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign prog_len  = prog_len_q;
  assign instr     = (state_q == RUN && {1'b0, addr} < 9'(DEPTH)) ? mem[addr[AW-1:0]] : PAD_WORD;
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    hold_cnt_d  = hold_cnt_q;
    ld_ready_d  = ld_ready_q;
    cpu_reset_d = cpu_reset_q;
    we          = 1'b0;
    wdata       = ld.ld_data;
    case (state_q)
      LOAD: if (accept) begin
        we         = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        prog_len_d = prog_len_q + 1'b1;
        if (at_end || ld.ld_last) begin
          state_d    = at_end ? HOLD : PAD;
          ld_ready_d = 1'b0;
        end
      end
      PAD: begin
        we       = 1'b1;
        wdata    = PAD_WORD;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = at_end ? HOLD : PAD;
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == 4'(RST_HOLD - 1)) begin
          state_d     = RUN;
          hold_cnt_d  = '0;
          cpu_reset_d = 1'b0;
        end
      end
      RUN: if (reload) begin
        state_d     = LOAD;
        wr_ptr_d    = '0;
        prog_len_d  = '0;
        cpu_reset_d = 1'b1;
        ld_ready_d  = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      hold_cnt_q  <= '0;
      ld_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      hold_cnt_q  <= hold_cnt_d;
      ld_ready_q  <= ld_ready_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end
  always_ff @(posedge clk)
    if (we && !reset) mem[wr_ptr_q[AW-1:0]] <= wdata;
endmodule

// File: tb/tb_mcpu5_prog_loader.sv
// tb_mcpu5_prog_loader: directed load/pad/hold/run scenarios checked through an expectation queue
module tb_mcpu5_prog_loader;
  localparam int         DEPTH    = 64;
  localparam int         RST_HOLD = 2;
  localparam logic [5:0] PADW     = 6'h00;
  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
    logic [15:0] act;
  } exp_t;
  logic       clk = 1'b0, reset = 1'b1, reload = 1'b0, chk_v = 1'b0;
  logic [7:0] addr = '0;
  logic [5:0] instr;
  logic       cpu_reset;
  logic [8:0] prog_len;
  int         checks = 0, errors = 0;
  exp_t       sb[$];
  mcpu5_prog_loader_if ld ();
  mcpu5_prog_loader #(.DEPTH(DEPTH), .PAD_WORD(PADW), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset(reset), .ld(ld.slave), .reload(reload),
    .addr(addr), .instr(instr), .cpu_reset(cpu_reset), .prog_len(prog_len)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (chk_v) begin
      while (sb.size() > 0) begin
        automatic exp_t e = sb.pop_front();
        automatic logic [15:0] a = e.kind == 0 ? 16'(instr) :
                                   e.kind == 1 ? 16'(prog_len) :
                                   e.kind == 2 ? 16'(cpu_reset) :
                                   e.kind == 3 ? 16'(ld.ld_ready) : e.act;
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
        end
      end
    end
  end
  task automatic push(string n, int k, logic [15:0] e, logic [15:0] a = '0);
    sb.push_back('{n, k, e, a});
  endtask
  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic check_now;
    chk_v = 1'b1;
    tick(1);
    chk_v = 1'b0;
  endtask
  task automatic send(logic [5:0] d, logic last);
    bit ok = 0;
    int t = 0;
    ld.ld_valid = 1'b1; ld.ld_data = d; ld.ld_last = last;
    while (!ok && t < 200) begin
      @(negedge clk); ok = ld.ld_ready;
      @(posedge clk); #1; t++;
    end
    ld.ld_valid = 1'b0; ld.ld_last = 1'b0;
    if (!ok) push("accept_timeout", 9, 16'd1, 16'd0);
  endtask
  task automatic wait_run(int exp_cycles);
    int n = 0;
    while (cpu_reset === 1'b1 && n < 1000) begin tick(1); n++; end
    push("reset_cycles", 9, 16'(exp_cycles), 16'(n));
  endtask
  task automatic rd(logic [7:0] a, logic [5:0] e);
    addr = a;
    push($sformatf("instr@%0d", a), 0, 16'(e));
    check_now();
  endtask
  task automatic pulse_reload;
    reload = 1'b1; tick(1); reload = 1'b0;
  endtask
  initial begin
    automatic logic [5:0] prog[5] = '{6'h01, 6'h22, 6'h0C, 6'h3E, 6'h30};
    ld.ld_valid = 1'b0; ld.ld_data = '0; ld.ld_last = 1'b0;
    tick(3);
    reset = 1'b0;
    push("rst_prog_len", 1, 0); push("rst_cpu_reset", 2, 1); push("rst_ld_ready", 3, 1);
    push("rst_instr", 0, 16'(PADW));
    check_now();
    send(6'h3B, 0); send(6'h01, 0); send(6'h3F, 1);
    wait_run(DEPTH - 3 + RST_HOLD);
    push("run_ld_ready", 3, 0);
    rd(0, 6'h3B); rd(1, 6'h01); rd(2, 6'h3F); rd(3, PADW);
    push("s1_prog_len", 1, 3); check_now();
    pulse_reload();
    push("rl_cpu_reset", 2, 1); push("rl_ld_ready", 3, 1); push("rl_prog_len", 1, 0);
    check_now();
    send(6'h3B, 0);
    tick(5);
    push("stall_prog_len", 1, 1); push("stall_ld_ready", 3, 1); push("stall_cpu_reset", 2, 1);
    check_now();
    send(6'h01, 0); send(6'h3F, 1);
    wait_run(DEPTH - 3 + RST_HOLD);
    rd(0, 6'h3B); rd(1, 6'h01); rd(2, 6'h3F); rd(3, PADW);
    push("s2_prog_len", 1, 3); check_now();
    pulse_reload();
    for (int i = 0; i < DEPTH; i++) send(6'(i * 5 + 1), 0);
    wait_run(RST_HOLD);
    push("full_prog_len", 1, 16'(DEPTH)); check_now();
    rd(8'(DEPTH - 1), 6'((DEPTH - 1) * 5 + 1)); rd(0, 6'h01); rd(10, 6'h33);
    pulse_reload();
    send(6'h15, 1);
    wait_run(DEPTH - 1 + RST_HOLD);
    rd(0, 6'h15); rd(1, PADW); rd(8'(DEPTH - 1), PADW);
    push("s4_prog_len", 1, 1); check_now();
    pulse_reload();
    send(6'h07, 0); send(6'h08, 0);
    reset = 1'b1; tick(1); reset = 1'b0;
    push("mid_rst_prog_len", 1, 0); push("mid_rst_cpu_reset", 2, 1); push("mid_rst_ld_ready", 3, 1);
    check_now();
    send(6'h2A, 0);
    pulse_reload();
    push("ign_rl_prog_len", 1, 1); push("ign_rl_ld_ready", 3, 1); push("ign_rl_cpu_reset", 2, 1);
    check_now();
    send(6'h2B, 1);
    wait_run(DEPTH - 2 + RST_HOLD);
    rd(0, 6'h2A); rd(1, 6'h2B); rd(2, PADW);
    push("s5_prog_len", 1, 2); check_now();
    pulse_reload();
    for (int i = 0; i < 5; i++) send(prog[i], i == 4);
    wait_run(DEPTH - 5 + RST_HOLD);
    rd(8'(DEPTH), PADW); rd(8'd255, PADW);
    for (int pc = 0; pc < 5; pc++) rd(8'(pc), prog[pc]);
    rd(8'd5, PADW);
    checks++;
    if (instr !== PADW) begin
      errors++;
      $display("FAIL final_instr: got %0h expected %0h", instr, PADW);
    end
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL final_cpu_reset: got %0h expected 0", cpu_reset);
    end
    checks++;
    if (prog_len !== 9'd5) begin
      errors++;
      $display("FAIL final_prog_len: got %0h expected 5", prog_len);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
